// File: rtl/qpsk_demod_if.sv
// QPSK detector bus: sample/LO input stream and the valid/ready bit-pair result.
// The soft sums exist only when QPSK_SOFT_OUT_EN is defined.
interface qpsk_demod_if #(
   parameter int unsigned SAMPLES_PER_SYM = 16,
   parameter int unsigned IN_W            = 10,
   parameter int unsigned LO_W            = 9
);
   localparam int unsigned ACC_W = IN_W + LO_W + $clog2(SAMPLES_PER_SYM);

   logic                   sym_sync;
   logic                   in_valid;
   logic signed [IN_W-1:0] qpsk_in;
   logic signed [LO_W-1:0] lo_cos_in;
   logic signed [LO_W-1:0] lo_sin_in;
   logic                   out_valid;
   logic                   out_ready;
   logic                   i_bit;
   logic                   q_bit;
   logic                   overrun;
`ifdef QPSK_SOFT_OUT_EN
   logic signed [ACC_W-1:0] soft_i;
   logic signed [ACC_W-1:0] soft_q;
`endif

   // Sample source and result consumer.
   modport master (
      output sym_sync, in_valid, qpsk_in, lo_cos_in, lo_sin_in, out_ready,
`ifdef QPSK_SOFT_OUT_EN
      input  soft_i, soft_q,
`endif
      input  out_valid, i_bit, q_bit, overrun
   );

   // The detector itself.
   modport slave (
      input  sym_sync, in_valid, qpsk_in, lo_cos_in, lo_sin_in, out_ready,
`ifdef QPSK_SOFT_OUT_EN
      output soft_i, soft_q,
`endif
      output out_valid, i_bit, q_bit, overrun
   );
endinterface

// File: rtl/qpsk_demod.sv
// Coherent QPSK detector. Each sample is mixed with the aligned cos/sin references,
// the products are integrated over one symbol and the sign of each sum gives I/Q.
// Results leave through a valid/ready holding register; overwriting an unconsumed
// result sets the sticky overrun flag.
// Optional feature: define QPSK_SOFT_OUT_EN to also expose the signed symbol sums.
module qpsk_demod #(
   parameter int unsigned SAMPLES_PER_SYM = 16,
   parameter int unsigned IN_W            = 10,
   parameter int unsigned LO_W            = 9
) (
   input logic          clk,
   input logic          rst_n,
   qpsk_demod_if.slave  bus
);
   localparam int unsigned PROD_W = IN_W + LO_W;
   localparam int unsigned ACC_W  = IN_W + LO_W + $clog2(SAMPLES_PER_SYM);
   localparam int unsigned CNT_W  = $clog2(SAMPLES_PER_SYM);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(SAMPLES_PER_SYM - 1);

   logic signed [PROD_W-1:0] prod_i, prod_q;
   logic signed [ACC_W-1:0]  prod_i_ext, prod_q_ext;
   logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [ACC_W-1:0]  sum_i, sum_q;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     sym_done;
   logic                     out_valid_q, out_valid_d;
   logic                     i_bit_q, i_bit_d, q_bit_q, q_bit_d;
   logic                     overrun_q, overrun_d;
`ifdef QPSK_SOFT_OUT_EN
   logic signed [ACC_W-1:0]  soft_i_q, soft_i_d, soft_q_q, soft_q_d;
`endif

   // Full-width signed mixing products, sign-extended to accumulator width.
   always_comb begin
      prod_i     = PROD_W'(bus.qpsk_in) * PROD_W'(bus.lo_cos_in);
      prod_q     = PROD_W'(bus.qpsk_in) * PROD_W'(bus.lo_sin_in);
      prod_i_ext = ACC_W'(prod_i);
      prod_q_ext = ACC_W'(prod_q);
      sum_i      = acc_i_q + prod_i_ext;
      sum_q      = acc_q_q + prod_q_ext;
   end

   // Integrator and symbol counter; sym_sync restarts the symbol and drops the partial sum.
   always_comb begin
      acc_i_d  = acc_i_q;
      acc_q_d  = acc_q_q;
      cnt_d    = cnt_q;
      sym_done = 1'b0;
      if (bus.sym_sync) begin
         if (bus.in_valid) begin
            acc_i_d = prod_i_ext;
            acc_q_d = prod_q_ext;
            cnt_d   = CNT_W'(1);
         end else begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
         end
      end else if (bus.in_valid) begin
         if (cnt_q == CntLast) begin
            sym_done = 1'b1;
            acc_i_d  = '0;
            acc_q_d  = '0;
            cnt_d    = '0;
         end else begin
            acc_i_d = sum_i;
            acc_q_d = sum_q;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   // Slicer and output holding register; a new result always wins over a pending one.
   always_comb begin
      out_valid_d = out_valid_q;
      i_bit_d     = i_bit_q;
      q_bit_d     = q_bit_q;
      overrun_d   = overrun_q;
`ifdef QPSK_SOFT_OUT_EN
      soft_i_d    = soft_i_q;
      soft_q_d    = soft_q_q;
`endif
      if (sym_done) begin
         out_valid_d = 1'b1;
         i_bit_d     = ~sum_i[ACC_W-1];  // zero slices to 1
         q_bit_d     = ~sum_q[ACC_W-1];
`ifdef QPSK_SOFT_OUT_EN
         soft_i_d    = sum_i;
         soft_q_d    = sum_q;
`endif
         if (out_valid_q && !bus.out_ready) begin
            overrun_d = 1'b1;
         end
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         i_bit_q     <= 1'b0;
         q_bit_q     <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef QPSK_SOFT_OUT_EN
         soft_i_q    <= '0;
         soft_q_q    <= '0;
`endif
      end else begin
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         i_bit_q     <= i_bit_d;
         q_bit_q     <= q_bit_d;
         overrun_q   <= overrun_d;
`ifdef QPSK_SOFT_OUT_EN
         soft_i_q    <= soft_i_d;
         soft_q_q    <= soft_q_d;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.i_bit     = i_bit_q;
   assign bus.q_bit     = q_bit_q;
   assign bus.overrun   = overrun_q;
`ifdef QPSK_SOFT_OUT_EN
   assign bus.soft_i    = soft_i_q;
   assign bus.soft_q    = soft_q_q;
`endif
endmodule

// File: tb/tb_qpsk_demod.sv
// Bench for qpsk_demod with SAMPLES_PER_SYM=4. Expected bit pairs (and soft sums when
// QPSK_SOFT_OUT_EN is defined) are computed from the driven samples and queued; a
// monitor pops them on every out_valid && out_ready transfer.
// LO amplitude is 255: +256 does not fit a 9-bit signed reference.
module tb_qpsk_demod;
   localparam int unsigned SPS = 4;

   typedef struct {
      bit     i;
      bit     q;
      longint si;
      longint sq;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   int   vcycles = 0;
   exp_t sb[$];
   int   cu[4] = '{1, 0, -1, 0};
   int   su[4] = '{0, 1, 0, -1};

   qpsk_demod_if #(.SAMPLES_PER_SYM(SPS)) bus ();

   qpsk_demod #(.SAMPLES_PER_SYM(SPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      bus.sym_sync = 1'b0;
      for (int c = 0; c < n; c++) step();
   endtask

   // Drive sample k of symbol (ib,qb); returns the products the detector should form.
   task automatic drive_sample(input bit ib, input bit qb, input int k, input bit sync,
                               output longint pi, output longint pq);
      int s, lc, ls;
      s  = (ib ? 256 : -256) * cu[k] + (qb ? 256 : -256) * su[k];
      lc = 255 * cu[k];
      ls = 255 * su[k];
      bus.qpsk_in   = 10'(s);
      bus.lo_cos_in = 9'(lc);
      bus.lo_sin_in = 9'(ls);
      bus.in_valid  = 1'b1;
      bus.sym_sync  = sync;
      pi = longint'(s) * lc;
      pq = longint'(s) * ls;
   endtask

   task automatic send_symbol(input bit ib, input bit qb, input bit sync, input bit gap,
                              input bit push);
      longint si = 0, sq = 0, pi, pq;
      exp_t e;
      for (int k = 0; k < SPS; k++) begin
         if (gap) begin
            bus.in_valid  = 1'b0;
            bus.sym_sync  = 1'b0;
            bus.qpsk_in   = 10'($urandom);
            bus.lo_cos_in = 9'($urandom);
            bus.lo_sin_in = 9'($urandom);
            step();
         end
         drive_sample(ib, qb, k, sync && (k == 0), pi, pq);
         si += pi;
         sq += pq;
         if (k == SPS - 1 && push) begin
            e.i = (si >= 0);
            e.q = (sq >= 0);
            e.si = si;
            e.sq = sq;
            sb.push_back(e);
         end
         step();
      end
      bus.in_valid = 1'b0;
      bus.sym_sync = 1'b0;
      check("lat_valid", longint'(bus.out_valid), 1);
      check("lat_i", longint'(bus.i_bit), longint'(ib));
      check("lat_q", longint'(bus.q_bit), longint'(qb));
   endtask

   // Scoreboard monitor, sampling away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.out_valid) vcycles++;
         if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               check("sb_nonempty", longint'(sb.size()), 1);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_i", longint'(bus.i_bit), longint'(e.i));
               check("sb_q", longint'(bus.q_bit), longint'(e.q));
`ifdef QPSK_SOFT_OUT_EN
               check("sb_soft_i", longint'(bus.soft_i), e.si);
               check("sb_soft_q", longint'(bus.soft_q), e.sq);
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, h0;
      longint pi, pq;
      rst_n         = 1'b0;
      bus.sym_sync  = 1'b0;
      bus.in_valid  = 1'b0;
      bus.qpsk_in   = '0;
      bus.lo_cos_in = '0;
      bus.lo_sin_in = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      check("rst_valid", longint'(bus.out_valid), 0);
      check("rst_i", longint'(bus.i_bit), 0);
      check("rst_q", longint'(bus.q_bit), 0);
      check("rst_overrun", longint'(bus.overrun), 0);
      rst_n = 1'b1;
      step();

      // 1: I=1,Q=1; sums are 2*256*255 = 130560 each
      send_symbol(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef QPSK_SOFT_OUT_EN
      check("t1_soft_i", longint'(bus.soft_i), 130560);
      check("t1_soft_q", longint'(bus.soft_q), 130560);
`endif
      idle(2);
      check("t1_drop", longint'(bus.out_valid), 0);

      // 2: back-to-back symbols 00, 01, 10; one valid cycle per symbol
      v0 = vcycles;
      send_symbol(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_symbol(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      send_symbol(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("t2_vcycles", longint'(vcycles - v0), 3);

      // 3: consumer stalls for two symbols; the second overwrites the first
      bus.out_ready = 1'b0;
      send_symbol(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("t3_hold_valid", longint'(bus.out_valid), 1);
      check("t3_hold_i", longint'(bus.i_bit), 1);
      check("t3_hold_q", longint'(bus.q_bit), 0);
      check("t3_no_ovr_yet", longint'(bus.overrun), 0);
      send_symbol(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t3_overrun", longint'(bus.overrun), 1);
      bus.out_ready = 1'b1;
      idle(2);
      check("t3_drained", longint'(bus.out_valid), 0);
      send_symbol(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("t3_sticky", longint'(bus.overrun), 1);

      // 4: sym_sync after two samples restarts the symbol; one output only
      h0 = hs_cnt;
      drive_sample(1'b0, 1'b1, 0, 1'b0, pi, pq);
      step();
      drive_sample(1'b0, 1'b1, 1, 1'b0, pi, pq);
      step();
      send_symbol(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      idle(3);
      check("t4_one_out", longint'(hs_cnt - h0), 1);

      // 5: in_valid alternates; garbage on invalid cycles must be ignored
      send_symbol(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);
      send_symbol(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      idle(2);

      // 6: reset mid-symbol clears everything, next symbol is clean
      drive_sample(1'b0, 1'b0, 0, 1'b0, pi, pq);
      step();
      drive_sample(1'b0, 1'b0, 1, 1'b0, pi, pq);
      step();
      drive_sample(1'b0, 1'b0, 2, 1'b0, pi, pq);
      step();
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      check("t6_valid", longint'(bus.out_valid), 0);
      check("t6_i", longint'(bus.i_bit), 0);
      check("t6_q", longint'(bus.q_bit), 0);
      check("t6_overrun", longint'(bus.overrun), 0);
`ifdef QPSK_SOFT_OUT_EN
      check("t6_soft_i", longint'(bus.soft_i), 0);
      check("t6_soft_q", longint'(bus.soft_q), 0);
`endif
      rst_n = 1'b1;
      send_symbol(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      check("t6_no_ovr", longint'(bus.overrun), 0);
      check("sb_drain", longint'(sb.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
